// File: rtl/dac_out_stage.sv
`default_nettype none
// ============================================================================
// Module  : dac_out_stage
// Purpose : DAC output stage with inverse-sinc/bypass, round+saturate, mute ramp,
//           offset-binary coding, underrun flag and clip counter.
// Rev     : 1.0
// ============================================================================
module dac_out_stage #(
  parameter int W            = 14,
  parameter int WC           = 12,
  parameter int C_EDGE       = -64,
  parameter int C_CENTER     = 1152,
  parameter int SHIFT        = 10,
  parameter int MUTE_STEPS   = 4,
  parameter int UNDERRUN_MAX = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_data,
  input  logic         val_in,
  input  logic         c_comp_dac,
  input  logic         c_mute,
  output logic [W-1:0] o_dac,
  output logic         val_out,
  output logic         underrun,
  output logic [15:0]  sat_cnt
);

  localparam int c_aw   = W + WC + 2;
  localparam int c_kw   = $clog2(MUTE_STEPS + 1);
  localparam int c_gw   = $clog2(UNDERRUN_MAX + 1);
  localparam int c_half = 1 << (SHIFT - 1);
  localparam int c_ymax = (1 << (W - 1)) - 1;
  localparam int c_ymin = -(1 << (W - 1));

  localparam logic signed [WC-1:0] c_edge   = WC'(C_EDGE);
  localparam logic signed [WC-1:0] c_center = WC'(C_CENTER);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DOWN  = 2'd1,
    ST_MUTED = 2'd2,
    ST_UP    = 2'd3
  } state_e;

  // --------------------------------------------------------------------------
  // Stage 1: tap delay line; the path select rides along with each sample
  // --------------------------------------------------------------------------
  logic signed [W-1:0] x0_q, x1_q, x2_q;
  logic                comp_q;
  logic                v1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      x0_q   <= '0;
      x1_q   <= '0;
      x2_q   <= '0;
      comp_q <= 1'b0;
      v1_q   <= 1'b0;
    end else begin
      v1_q <= val_in;
      if (val_in) begin
        x0_q   <= i_data;
        x1_q   <= x0_q;
        x2_q   <= x1_q;
        comp_q <= c_comp_dac;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: 3-tap MAC, round half up, clip to the signed output range
  // --------------------------------------------------------------------------
  logic signed [c_aw-1:0] w_acc;
  logic signed [c_aw-1:0] w_rnd;
  logic signed [c_aw-1:0] w_shr;
  logic signed [W-1:0]    w_y;
  logic                   w_clip;

  always_comb begin
    w_acc  = (c_aw'(x0_q) + c_aw'(x2_q)) * c_aw'(c_edge)
           + c_aw'(x1_q) * c_aw'(c_center);
    w_rnd  = w_acc + c_aw'(c_half);
    w_shr  = w_rnd >>> SHIFT;
    w_y    = w_shr[W-1:0];
    w_clip = 1'b0;
    // Bypass taps the centre register so both paths share one group delay.
    if (!comp_q) begin
      w_y = x1_q;
    end else if (w_shr > c_aw'(c_ymax)) begin
      w_y    = W'(c_ymax);
      w_clip = 1'b1;
    end else if (w_shr < c_aw'(c_ymin)) begin
      w_y    = W'(c_ymin);
      w_clip = 1'b1;
    end
  end

  logic signed [W-1:0] y_q;
  logic                clip_q;
  logic                v2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q    <= '0;
      clip_q <= 1'b0;
      v2_q   <= 1'b0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        y_q    <= w_y;
        clip_q <= w_clip;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 3: mute ramp FSM. A change of c_mute takes effect on the same
  // output it is seen with; k is the shift applied to the next output.
  // --------------------------------------------------------------------------
  state_e              state_q, state_d;
  state_e              w_mode;
  logic [c_kw-1:0]     k_q, k_d;
  logic [c_kw-1:0]     w_k;
  logic signed [W-1:0] w_g;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    w_mode  = state_q;
    w_k     = k_q;
    w_g     = y_q;
    state_d = state_q;
    k_d     = k_q;

    case (state_q)
      ST_RUN: begin
        if (c_mute) begin
          w_mode = ST_DOWN;
          w_k    = c_kw'(1);
        end
      end
      ST_DOWN: begin
        if (!c_mute) w_mode = ST_UP;
      end
      ST_MUTED: begin
        if (!c_mute) begin
          w_mode = ST_UP;
          w_k    = c_kw'(MUTE_STEPS);
        end
      end
      default: begin
        if (c_mute) w_mode = ST_DOWN;
      end
    endcase

    case (w_mode)
      ST_DOWN: begin
        w_g = y_q >>> w_k;
        if (v2_q) begin
          if (w_k == c_kw'(MUTE_STEPS)) begin
            state_d = ST_MUTED;
            k_d     = w_k;
          end else begin
            state_d = ST_DOWN;
            k_d     = w_k + c_kw'(1);
          end
        end
      end
      ST_UP: begin
        w_g = y_q >>> w_k;
        if (v2_q) begin
          if (w_k == c_kw'(1)) begin
            state_d = ST_RUN;
            k_d     = '0;
          end else begin
            state_d = ST_UP;
            k_d     = w_k - c_kw'(1);
          end
        end
      end
      ST_MUTED: begin
        w_g = '0;
      end
      default: begin
        w_g = y_q;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output register: offset-binary code, strobe, clip counter
  // --------------------------------------------------------------------------
  logic [W-1:0] o_dac_q;
  logic         val_out_q;
  logic [15:0]  sat_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      o_dac_q   <= {1'b1, {(W-1){1'b0}}};
      val_out_q <= 1'b0;
      sat_cnt_q <= '0;
    end else begin
      val_out_q <= v2_q;
      if (v2_q) begin
        o_dac_q <= {~w_g[W-1], w_g[W-2:0]};
        if (clip_q && (sat_cnt_q != 16'hFFFF)) begin
          sat_cnt_q <= sat_cnt_q + 16'd1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Underrun: idle-clock counter armed by the first sample after reset
  // --------------------------------------------------------------------------
  logic            armed_q;
  logic [c_gw-1:0] gap_q;
  logic            underrun_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q    <= 1'b0;
      gap_q      <= '0;
      underrun_q <= 1'b0;
    end else if (val_in) begin
      armed_q <= 1'b1;
      gap_q   <= '0;
    end else if (armed_q && (gap_q != c_gw'(UNDERRUN_MAX))) begin
      gap_q <= gap_q + c_gw'(1);
      if (gap_q == c_gw'(UNDERRUN_MAX - 1)) begin
        underrun_q <= 1'b1;
      end
    end
  end

  assign o_dac    = o_dac_q;
  assign val_out  = val_out_q;
  assign underrun = underrun_q;
  assign sat_cnt  = sat_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_out_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_dac_out_stage
// Purpose : directed vectors and random traffic against a sample-level model.
// Rev     : 1.0
// ============================================================================
module tb_dac_out_stage;

  logic        clk        = 1'b0;
  logic        rst        = 1'b1;
  logic [13:0] i_data     = '0;
  logic        val_in     = 1'b0;
  logic        c_comp_dac = 1'b0;
  logic        c_mute     = 1'b0;
  logic [13:0] o_dac;
  logic        val_out;
  logic        underrun;
  logic [15:0] sat_cnt;

  always #5 clk = ~clk;

  dac_out_stage dut (
    .clk        (clk),
    .rst        (rst),
    .i_data     (i_data),
    .val_in     (val_in),
    .c_comp_dac (c_comp_dac),
    .c_mute     (c_mute),
    .o_dac      (o_dac),
    .val_out    (val_out),
    .underrun   (underrun),
    .sat_cnt    (sat_cnt)
  );

  typedef struct {
    int y;
    bit clip;
    int due;
  } pend_t;

  pend_t pq[$];
  int h0 = 0, h1 = 0, h2 = 0;
  int mode = 0;       // 0 run, 1 ramping down, 2 muted, 3 ramping up
  int katt = 0;
  int exp_dac = 8192;
  bit exp_val = 1'b0;
  int exp_sat = 0;
  bit exp_und = 1'b0;
  bit armed = 1'b0;
  int gap = 0;
  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sx14(input logic [13:0] v);
    return int'($signed(v));
  endfunction

  task automatic calc(input int a, input int b, input int c, input bit comp,
                      output int y, output bit clip);
    int acc;
    int t;
    clip = 1'b0;
    if (!comp) begin
      y = b;
    end else begin
      acc = -64 * (a + c) + 1152 * b;
      t   = (acc + 512) >>> 10;
      if (t > 8191) begin
        y = 8191;  clip = 1'b1;
      end else if (t < -8192) begin
        y = -8192; clip = 1'b1;
      end else begin
        y = t;
      end
    end
  endtask

  task automatic gain(input int y, output int g);
    if (mode == 0 && c_mute) begin
      mode = 1; katt = 1;
    end else if (mode == 2 && !c_mute) begin
      mode = 3; katt = 4;
    end else if (mode == 1 && !c_mute) begin
      mode = 3;
    end else if (mode == 3 && c_mute) begin
      mode = 1;
    end
    case (mode)
      1: begin
        g = y >>> katt;
        if (katt == 4) mode = 2; else katt++;
      end
      3: begin
        g = y >>> katt;
        if (katt == 1) begin mode = 0; katt = 0; end else katt--;
      end
      2:       g = 0;
      default: g = y;
    endcase
  endtask

  task automatic model_edge();
    pend_t p;
    int    g;
    int    y;
    bit    clip;
    if (rst) begin
      h0 = 0; h1 = 0; h2 = 0;
      pq.delete();
      mode = 0; katt = 0;
      exp_dac = 8192; exp_val = 1'b0; exp_sat = 0; exp_und = 1'b0;
      armed = 1'b0; gap = 0;
    end else begin
      exp_val = 1'b0;
      if (pq.size() > 0 && pq[0].due == cyc) begin
        p = pq.pop_front();
        gain(p.y, g);
        exp_dac = g + 8192;
        exp_val = 1'b1;
        if (p.clip && exp_sat < 65535) exp_sat++;
      end
      if (val_in) begin
        h2 = h1; h1 = h0; h0 = sx14(i_data);
        calc(h0, h1, h2, c_comp_dac, y, clip);
        p.y = y; p.clip = clip; p.due = cyc + 2;
        pq.push_back(p);
        armed = 1'b1; gap = 0;
      end else if (armed) begin
        gap++;
        if (gap >= 16) exp_und = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("val_out",  val_out,  exp_val);
    chk("o_dac",    o_dac,    exp_dac);
    chk("sat_cnt",  sat_cnt,  exp_sat);
    chk("underrun", underrun, exp_und);
  endtask

  task automatic idle(input int n);
    val_in = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send(input int d, input bit comp);
    i_data     = 14'(d);
    c_comp_dac = comp;
    val_in     = 1'b1;
    tick();
    val_in     = 1'b0;
  endtask

  // One sample every 4 clocks; the update must appear exactly 2 edges later.
  task automatic send_expect(input string tag, input int d, input bit comp, input int code);
    send(d, comp);
    tick();
    tick();
    chk({tag, "_strobe"}, val_out, 1);
    chk(tag, o_dac, code);
    tick();
  endtask

  int mute_dn[6] = '{10240, 9216, 8704, 8448, 8192, 8192};
  int mute_up[5] = '{8448, 8704, 9216, 10240, 12288};

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_odac", o_dac, 32'h2000);
    chk("rst_val",  val_out, 0);
    chk("rst_und",  underrun, 0);
    chk("rst_sat",  sat_cnt, 0);
    rst = 1'b0;
    tick();

    send_expect("byp0", 1000, 1'b0, 'h2000);
    send_expect("byp1", 0,    1'b0, 'h23E8);
    send_expect("byp2", 0,    1'b0, 'h2000);

    send_expect("cmp0", 1024, 1'b1, 'h1FC0);
    send_expect("cmp1", 0,    1'b1, 'h2480);
    send_expect("cmp2", 0,    1'b1, 'h1FC0);

    send_expect("clip0", 8191, 1'b1, 'h1E00);
    for (int i = 1; i < 6; i++) begin
      if (i % 2 == 1) send_expect("clip_hi", -8192, 1'b1, 'h3FFF);
      else            send_expect("clip_lo",  8191, 1'b1, 'h0000);
    end
    chk("sat_total", sat_cnt, 5);

    c_mute = 1'b0;
    send(4096, 1'b0); idle(3);
    send(4096, 1'b0); idle(3);
    send_expect("dc_run", 4096, 1'b0, 'h3000);
    c_mute = 1'b1;
    for (int i = 0; i < 6; i++) send_expect("mute_dn", 4096, 1'b0, mute_dn[i]);
    c_mute = 1'b0;
    for (int i = 0; i < 5; i++) send_expect("mute_up", 4096, 1'b0, mute_up[i]);

    idle(12);
    chk("und_15", underrun, 0);
    idle(1);
    chk("und_16", underrun, 1);
    chk("und_hold", o_dac, 'h3000);
    send(100, 1'b0); send(200, 1'b0); idle(4);
    chk("und_sticky", underrun, 1);
    rst = 1'b1; tick(); tick();
    chk("und_clr", underrun, 0);
    rst = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      int r;
      int d;
      r = int'($urandom_range(0, 999));
      if (r < 3) begin
        rst = 1'b1; tick(); rst = 1'b0;
      end else if (r < 6) begin
        idle(20);
      end else begin
        if ($urandom_range(0, 7) == 0) c_mute = ~c_mute;
        if ($urandom_range(0, 9) < 7) begin
          case ($urandom_range(0, 3))
            0:       d = ($urandom_range(0, 1) == 1) ? 8191 : -8192;
            1:       d = int'($urandom_range(0, 16383)) - 8192;
            default: d = int'($urandom_range(0, 1023)) - 512;
          endcase
          send(d, $urandom_range(0, 3) != 0);
        end else begin
          tick();
        end
      end
    end

    idle(4);
    rst = 1'b1; tick();
    chk("end_rst_odac", o_dac, 32'h2000);
    chk("end_rst_sat",  sat_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
